// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill sequencer: arbitrates demand misses over
// next-line prefetches, issues one line request to memory with a timeout,
// then writes the returned line into the cache and returns the demand word.
module icache_refill_ctrl #(
  parameter int unsigned CACHE_SIZE = 8192,
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned IW        = $clog2(CACHE_SIZE * 8 / CACHE_LINE),
  localparam int unsigned TGW       = 32 - IW - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dem_req,
  input  logic [31:0]     dem_addr,
  output logic            dem_ack,
  output logic            dem_done,
  output logic [31:0]     dem_word,
  input  logic            pf_req,
  input  logic [31:0]     pf_addr,
  output logic            pf_ack,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic            mem_ready,
  input  logic [127:0]    mem_data_in,
  output logic            fill_we,
  output logic [IW-1:0]   fill_index,
  output logic [TGW-1:0]  fill_tag,
  output logic [127:0]    fill_line,
  output logic            busy,
  output logic            err,
  output logic            err_dem
);

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          src_dem_q, src_dem_d;  // 1: demand owns the request, 0: prefetch
  logic [31:0]   timer_q, timer_d;
  logic [127:0]  line_q, line_d;
  logic          merge;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      src_dem_q <= 1'b0;
      timer_q   <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      src_dem_q <= src_dem_d;
      timer_q   <= timer_d;
      line_q    <= line_d;
    end
  end

  // Next-state logic and all outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    src_dem_d  = src_dem_q;
    timer_d    = timer_q;
    line_d     = line_q;
    dem_ack    = 1'b0;
    dem_done   = 1'b0;
    dem_word   = '0;
    pf_ack     = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fill_we    = 1'b0;
    fill_index = '0;
    fill_tag   = '0;
    fill_line  = '0;
    err        = 1'b0;
    err_dem    = 1'b0;
    merge      = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (dem_req) begin
          dem_ack   = 1'b1;
          addr_d    = dem_addr;
          src_dem_d = 1'b1;
          timer_d   = '0;
          state_d   = StReq;
        end else if (pf_req) begin
          pf_ack    = 1'b1;
          addr_d    = pf_addr;
          src_dem_d = 1'b0;
          timer_d   = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        timer_d  = timer_q + 32'd1;
        // A demand hitting the line already being prefetched rides along
        merge = !src_dem_q && dem_req && (dem_addr[31:2] == addr_q[31:2]);
        if (merge) begin
          dem_ack     = 1'b1;
          src_dem_d   = 1'b1;
          addr_d[1:0] = dem_addr[1:0];
        end
        if (mem_ready) begin
          line_d  = mem_data_in;
          state_d = StFill;
        end else if ((TIMEOUT != 0) && (timer_q == TIMEOUT - 1)) begin
          err     = 1'b1;
          err_dem = src_dem_d;
          state_d = StIdle;
        end
      end
      StFill: begin
        fill_we    = 1'b1;
        fill_index = addr_q[IW+1:2];
        fill_tag   = addr_q[31:IW+2];
        fill_line  = line_q;
        if (src_dem_q) begin
          dem_done = 1'b1;
          dem_word = line_q[{addr_q[1:0], 5'd0} +: 32];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Requests seen during reset are not accepted
    if (rst) begin
      dem_ack = 1'b0;
      pf_ack  = 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (TIMEOUT set to 4).
module tb_icache_refill_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          dem_req;
  logic [31:0]   dem_addr;
  logic          dem_ack;
  logic          dem_done;
  logic [31:0]   dem_word;
  logic          pf_req;
  logic [31:0]   pf_addr;
  logic          pf_ack;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic [127:0]  mem_data_in;
  logic          fill_we;
  logic [8:0]    fill_index;
  logic [20:0]   fill_tag;
  logic [127:0]  fill_line;
  logic          busy;
  logic          err;
  logic          err_dem;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LineA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LineB = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
  localparam logic [127:0] LineC = {32'h0c0c0c03, 32'h0c0c0c02, 32'h0c0c0c01, 32'h0c0c0c00};

  icache_refill_ctrl #(
    .CACHE_SIZE(8192),
    .CACHE_LINE(128),
    .TIMEOUT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dem_req    (dem_req),
    .dem_addr   (dem_addr),
    .dem_ack    (dem_ack),
    .dem_done   (dem_done),
    .dem_word   (dem_word),
    .pf_req     (pf_req),
    .pf_addr    (pf_addr),
    .pf_ack     (pf_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_data_in(mem_data_in),
    .fill_we    (fill_we),
    .fill_index (fill_index),
    .fill_tag   (fill_tag),
    .fill_line  (fill_line),
    .busy       (busy),
    .err        (err),
    .err_dem    (err_dem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; caller then drives and settles
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dem_req = 1'b0; dem_addr = '0; pf_req = 1'b0; pf_addr = '0;
    mem_ready = 1'b0; mem_data_in = '0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_err", err, 0);
    chk("rst_dem_done", dem_done, 0);

    // Demand accept and fill
    step(); dem_req = 1'b1; dem_addr = 32'h0000_1236; #1;
    chk("t1_dem_ack", dem_ack, 1);
    chk("t1_idle_busy", busy, 0);
    step(); dem_req = 1'b0; #1;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h0000_1234);
    chk("t1_ack_once", dem_ack, 0);
    step(); #1;
    chk("t1_mem_addr_stable", mem_addr, 32'h0000_1234);
    step(); mem_ready = 1'b1; mem_data_in = LineA; #1;
    chk("t1_no_fill_yet", fill_we, 0);
    step(); mem_ready = 1'b0; mem_data_in = '0; #1;
    chk("t1_fill_we", fill_we, 1);
    chk("t1_fill_index", fill_index, 9'h08D);
    chk("t1_fill_tag", fill_tag, 21'h000002);
    chk("t1_fill_line", fill_line, LineA);
    chk("t1_dem_done", dem_done, 1);
    chk("t1_dem_word", dem_word, 32'h33333333);
    chk("t1_fill_mem_req", mem_req, 0);
    step(); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_fill_we", fill_we, 0);
    chk("t1_idle_dem_word", dem_word, 0);
    chk("t1_idle_fill_line", fill_line, 0);

    // Simultaneous demand and prefetch
    dem_req = 1'b1; dem_addr = 32'h0000_2000; pf_req = 1'b1; pf_addr = 32'h0000_3000; #1;
    chk("t2_dem_ack", dem_ack, 1);
    chk("t2_pf_ack_blocked", pf_ack, 0);
    step(); dem_req = 1'b0; mem_ready = 1'b1; mem_data_in = LineB; #1;
    chk("t2_mem_addr_dem", mem_addr, 32'h0000_2000);
    chk("t2_pf_ack_req", pf_ack, 0);
    step(); mem_ready = 1'b0; #1;
    chk("t2_dem_done", dem_done, 1);
    chk("t2_dem_word", dem_word, 32'haaaa0000);
    chk("t2_pf_ack_fill", pf_ack, 0);
    step(); #1;
    chk("t2_pf_ack", pf_ack, 1);
    step(); pf_req = 1'b0; mem_ready = 1'b1; mem_data_in = LineC; #1;
    chk("t2_mem_addr_pf", mem_addr, 32'h0000_3000);
    step(); mem_ready = 1'b0; #1;
    chk("t2_pf_fill_we", fill_we, 1);
    chk("t2_pf_dem_done", dem_done, 0);
    chk("t2_pf_dem_word", dem_word, 0);
    step(); #1;

    // Merge a demand into an in-flight prefetch of the same line
    pf_req = 1'b1; pf_addr = 32'h0000_0100; #1;
    chk("t3_pf_ack", pf_ack, 1);
    step(); pf_req = 1'b0; dem_req = 1'b1; dem_addr = 32'h0000_0103; #1;
    chk("t3_merge_ack", dem_ack, 1);
    chk("t3_mem_addr", mem_addr, 32'h0000_0100);
    step(); dem_req = 1'b0; mem_ready = 1'b1; mem_data_in = LineB; #1;
    chk("t3_same_episode", mem_req, 1);
    chk("t3_no_reack", dem_ack, 0);
    step(); mem_ready = 1'b0; #1;
    chk("t3_dem_done", dem_done, 1);
    chk("t3_dem_word", dem_word, 32'hdddd0003);
    chk("t3_fill_index", fill_index, 9'h040);
    step(); #1;
    chk("t3_idle_mem_req", mem_req, 0);

    // Demand timeout after 4 REQ cycles
    dem_req = 1'b1; dem_addr = 32'h0000_0400; #1;
    chk("t4_ack", dem_ack, 1);
    step(); dem_req = 1'b0; #1;
    chk("t4_c1_err", err, 0);
    step(); step(); #1;
    chk("t4_c3_err", err, 0);
    step(); #1;
    chk("t4_err", err, 1);
    chk("t4_err_dem", err_dem, 1);
    chk("t4_no_fill", fill_we, 0);
    step(); #1;
    chk("t4_busy_after", busy, 0);
    chk("t4_err_pulse", err, 0);
    chk("t4_fill_after", fill_we, 0);

    // Prefetch timeout reports err_dem=0
    pf_req = 1'b1; pf_addr = 32'h0000_0500;
    step(); pf_req = 1'b0;
    step(); step(); step(); #1;
    chk("t4p_err", err, 1);
    chk("t4p_err_dem", err_dem, 0);
    step(); #1;

    // mem_ready on the threshold cycle wins over timeout
    dem_req = 1'b1; dem_addr = 32'h0000_0402;
    step(); dem_req = 1'b0;
    step(); step(); step(); mem_ready = 1'b1; mem_data_in = LineA; #1;
    chk("t4r_no_err", err, 0);
    step(); mem_ready = 1'b0; #1;
    chk("t4r_fill_we", fill_we, 1);
    chk("t4r_dem_word", dem_word, 32'h33333333);
    step(); #1;

    // Reset mid-REQ abandons the request
    dem_req = 1'b1; dem_addr = 32'h0000_0600;
    step(); dem_req = 1'b0; #1;
    chk("t5_mem_req", mem_req, 1);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("t5_mem_req_off", mem_req, 0);
    chk("t5_busy_off", busy, 0);
    chk("t5_mem_addr_off", mem_addr, 0);
    mem_ready = 1'b1; mem_data_in = LineC;
    step(); mem_ready = 1'b0; #1;
    chk("t5_no_fill", fill_we, 0);
    chk("t5_no_done", dem_done, 0);

    // Back-to-back demands to different lines
    dem_req = 1'b1; dem_addr = 32'h0000_1000; #1;
    chk("t6_ack_a", dem_ack, 1);
    step(); dem_addr = 32'h0000_2005; mem_ready = 1'b1; mem_data_in = LineA; #1;
    chk("t6_b_not_acked", dem_ack, 0);
    chk("t6_mem_addr_a", mem_addr, 32'h0000_1000);
    step(); mem_ready = 1'b0; #1;
    chk("t6_done_a", dem_done, 1);
    chk("t6_word_a", dem_word, 32'h11111111);
    chk("t6_b_not_acked_fill", dem_ack, 0);
    step(); #1;
    chk("t6_ack_b", dem_ack, 1);
    step(); dem_req = 1'b0; mem_ready = 1'b1; mem_data_in = LineB; #1;
    chk("t6_mem_addr_b", mem_addr, 32'h0000_2004);
    step(); mem_ready = 1'b0; #1;
    chk("t6_done_b", dem_done, 1);
    chk("t6_word_b", dem_word, 32'hbbbb0001);
    chk("t6_index_b", fill_index, 9'h001);
    chk("t6_tag_b", fill_tag, 21'h000004);
    step(); #1;
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
